// File: rtl/uart_frame_decoder.sv
// Turns a stream of UART bytes into framed payload: SYNC, LEN, LEN payload bytes, XOR checksum.
// A verified frame is buffered and then presented on a valid/ready byte stream with a last flag.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         MAX_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun
);

  localparam int             CW        = $clog2(MAX_LEN + 1);
  localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0]  ONE       = CW'(1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] len_reg;
  logic [CW-1:0] idx_reg;
  logic [CW-1:0] rd_reg;
  logic [7:0]    chk_reg;

  logic [7:0]    buffer [MAX_LEN];

  logic [CW-1:0] idx_next;
  logic [CW-1:0] rd_next;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_word;
  logic          len_bad;
  logic          buf_wr;

  assign idx_next = idx_reg + ONE;
  assign rd_next  = rd_reg + ONE;
  assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign buf_wr   = !rst && rx_valid && (state_reg == S_PAYLOAD);
  assign wr_addr  = idx_reg[AW-1:0];
  // Before the first beat the read port points at byte 0, afterwards at the next byte.
  assign rd_addr  = out_valid ? rd_next[AW-1:0] : '0;
  assign rd_word  = buffer[rd_addr];

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buffer[wr_addr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_HUNT;
      len_reg   <= '0;
      idx_reg   <= '0;
      rd_reg    <= '0;
      chk_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state_reg)
        S_HUNT: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_reg <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (len_bad) begin
              frame_err <= 1'b1;
              state_reg <= S_HUNT;
            end else begin
              len_reg   <= rx_data[CW-1:0];
              chk_reg   <= rx_data;
              idx_reg   <= '0;
              state_reg <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            chk_reg <= chk_reg ^ rx_data;
            idx_reg <= idx_next;
            if (idx_next == len_reg) begin
              state_reg <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (rx_valid) begin
            if (rx_data == chk_reg) begin
              frame_ok  <= 1'b1;
              rd_reg    <= '0;
              state_reg <= S_DRAIN;
            end else begin
              frame_err <= 1'b1;
              state_reg <= S_HUNT;
            end
          end
        end
        S_DRAIN: begin
          // Nothing can be accepted while the buffer is being emptied.
          overrun <= rx_valid;
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= rd_word;
            out_last  <= (len_reg == ONE);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_reg <= S_HUNT;
            end else begin
              rd_reg   <= rd_next;
              out_data <= rd_word;
              out_last <= (rd_next == len_reg - ONE);
            end
          end
        end
        default: begin
          state_reg <= S_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed frames plus randomized frames checked against a
// frame-level reference model (expected payload queue and event counts).
module tb_uart_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic [8:0] got_q[$];
  int ok_cnt, err_cnt, ovr_cnt, valid_cycles, multi_cnt, stab_viol, last_viol;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;
  logic rand_ready_en = 1'b0;

  uart_frame_decoder #(.SYNC_BYTE(8'hAA), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (out_valid) valid_cycles++;
      ok_cnt  += int'(frame_ok);
      err_cnt += int'(frame_err);
      ovr_cnt += int'(overrun);
      if (int'(frame_ok) + int'(frame_err) + int'(overrun) > 1) multi_cnt++;
      if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last)) stab_viol++;
      if (out_last && !out_valid) last_viol++;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic clear_mon();
    got_q.delete();
    ok_cnt = 0; err_cnt = 0; ovr_cnt = 0; valid_cycles = 0;
    multi_cnt = 0; stab_viol = 0; last_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    repeat (3) @(negedge clk);
    n = 0;
    while (out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: drain timeout, out_valid still %0b, required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({out_valid, out_last, frame_ok, frame_err, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%0b l=%0b ok=%0b err=%0b ovr=%0b, required all 0",
               out_valid, out_last, frame_ok, frame_err, overrun);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h, required 00", out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h03;
    @(negedge clk); rx_valid = 1'b0;
    #2;
    checks++;
    if (frame_ok !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ok_latency: got ok=%0b v=%0b, required ok=1 v=0", frame_ok, out_valid);
    end
    @(negedge clk); #2;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_beat: got v=%0b d=%02h l=%0b, required v=1 d=11 l=0",
               out_valid, out_data, out_last);
    end
    wait_idle("basic");
    checks++;
    if (ok_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_pulses: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt, err_cnt);
    end
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 9'h011 || got_q[1] !== 9'h022 || got_q[2] !== 9'h133) begin
      errors++;
      $display("FAIL basic_data: got %p, required '{011,022,133}", got_q);
    end
    $display("test_basic done: %0d beats", got_q.size());
  endtask

  task automatic test_bad_chk();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt != 1 || ok_cnt != 0 || valid_cycles != 0) begin
      errors++;
      $display("FAIL bad_chk: got err=%0d ok=%0d valid_cycles=%0d, required 1 0 0",
               err_cnt, ok_cnt, valid_cycles);
    end
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h55, 0); send_byte(8'h54, 0);
    wait_idle("bad_chk_recover");
    checks++;
    if (ok_cnt != 1 || got_q.size() != 1 || got_q[0] !== 9'h155) begin
      errors++;
      $display("FAIL bad_chk_recover: got ok=%0d beats=%p, required ok=1 '{155}", ok_cnt, got_q);
    end
    $display("test_bad_chk done");
  endtask

  task automatic test_bad_len();
    clear_mon();
    send_byte(8'hAA, 0); send_byte(8'h00, 2);
    send_byte(8'hAA, 0); send_byte(8'h11, 2);
    checks++;
    if (err_cnt != 2 || ok_cnt != 0 || valid_cycles != 0) begin
      errors++;
      $display("FAIL bad_len: got err=%0d ok=%0d valid_cycles=%0d, required 2 0 0",
               err_cnt, ok_cnt, valid_cycles);
    end
    // A MAX_LEN frame must still be accepted after the rejections.
    send_byte(8'hAA, 0); send_byte(8'h10, 0);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 3), 0);
    send_byte(8'h10 ^ 8'h00 ^ 8'h03 ^ 8'h06 ^ 8'h09 ^ 8'h0C ^ 8'h0F ^ 8'h12 ^ 8'h15 ^
              8'h18 ^ 8'h1B ^ 8'h1E ^ 8'h21 ^ 8'h24 ^ 8'h27 ^ 8'h2A ^ 8'h2D, 0);
    wait_idle("max_len");
    checks++;
    if (ok_cnt != 1 || got_q.size() != 16 || got_q[15] !== 9'h12D || got_q[14] !== 9'h02A) begin
      errors++;
      $display("FAIL max_len: got ok=%0d beats=%0d, required ok=1 beats=16 ending 02A,12D",
               ok_cnt, got_q.size());
    end
    $display("test_bad_len done");
  endtask

  task automatic test_stall();
    int bad;
    clear_mon();
    out_ready = 1'b0;
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'hAA, 0);
    send_byte(8'hAA, 0); send_byte(8'h02, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = (i == 2 || i == 4);
      rx_data  = 8'h7E;
      #2;
      if (out_valid !== 1'b1 || out_data !== 8'hAA || out_last !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d stalled cycles not showing v=1 d=AA l=0, required 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle("stall");
    checks++;
    if (ovr_cnt != 2 || ok_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL stall_pulses: got ovr=%0d ok=%0d err=%0d, required 2 1 0", ovr_cnt, ok_cnt, err_cnt);
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 9'h0AA || got_q[1] !== 9'h1AA || stab_viol != 0) begin
      errors++;
      $display("FAIL stall_data: got %p stab_viol=%0d, required '{0AA,1AA} 0", got_q, stab_viol);
    end
    $display("test_stall done");
  endtask

  task automatic test_noise();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h13, 0);
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    wait_idle("noise");
    checks++;
    if (ok_cnt != 1 || err_cnt != 0 || ovr_cnt != 0 || got_q.size() != 1 || got_q[0] !== 9'h142) begin
      errors++;
      $display("FAIL noise: got ok=%0d err=%0d ovr=%0d beats=%p, required 1 0 0 '{142}",
               ok_cnt, err_cnt, ovr_cnt, got_q);
    end
    $display("test_noise done");
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    @(negedge clk); rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge clk); rst = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (ok_cnt != 0 || err_cnt != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got ok=%0d err=%0d v=%0b, required 0 0 0", ok_cnt, err_cnt, out_valid);
    end
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    wait_idle("reset_mid_frame");
    checks++;
    if (ok_cnt != 1 || got_q.size() != 1 || got_q[0] !== 9'h101) begin
      errors++;
      $display("FAIL reset_recover: got ok=%0d beats=%p, required 1 '{101}", ok_cnt, got_q);
    end
    // Reset while a frame is waiting to be drained.
    clear_mon();
    out_ready = 1'b0;
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: got beats=%0d v=%0b err=%0d, required 0 0 0",
               got_q.size(), out_valid, err_cnt);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h42, 0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h43;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'hAA;  // lands on the last handshake: dropped
    @(negedge clk); rx_data = 8'hAA;                   // back in HUNT: starts a new frame
    @(negedge clk); rx_data = 8'h01;
    @(negedge clk); rx_data = 8'h77;
    @(negedge clk); rx_data = 8'h76;
    @(negedge clk); rx_valid = 1'b0;
    wait_idle("back_to_back");
    checks++;
    if (ovr_cnt != 1 || ok_cnt != 2 || err_cnt != 0) begin
      errors++;
      $display("FAIL back_to_back_pulses: got ovr=%0d ok=%0d err=%0d, required 1 2 0", ovr_cnt, ok_cnt, err_cnt);
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 9'h142 || got_q[1] !== 9'h177) begin
      errors++;
      $display("FAIL back_to_back_data: got %p, required '{142,177}", got_q);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [7:0] payload[$];
    logic [7:0] chk, b;
    int ok_exp, err_exp, kind, len, mism;
    clear_mon();
    ok_exp = 0; err_exp = 0;
    rand_ready_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        b = 8'($urandom_range(0, 255));
        send_byte((b == 8'hAA) ? 8'h55 : b, $urandom_range(0, 1));
      end
      kind = $urandom_range(0, 3);
      send_byte(8'hAA, $urandom_range(0, 1));
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        send_byte(8'(len), 0);
        err_exp++;
      end else begin
        len = $urandom_range(1, 16);
        payload.delete();
        for (int i = 0; i < len; i++)
          payload.push_back(($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom_range(0, 255)));
        chk = 8'(len);
        foreach (payload[i]) chk = chk ^ payload[i];
        send_byte(8'(len), $urandom_range(0, 1));
        foreach (payload[i]) send_byte(payload[i], $urandom_range(0, 1));
        if (kind == 2) begin
          send_byte(chk ^ 8'($urandom_range(1, 255)), 0);
          err_exp++;
        end else begin
          send_byte(chk, 0);
          ok_exp++;
          foreach (payload[i]) exp_q.push_back({(i == len - 1), payload[i]});
        end
      end
      wait_idle("random");
    end
    rand_ready_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    checks++;
    if (ok_cnt != ok_exp || err_cnt != err_exp || ovr_cnt != 0) begin
      errors++;
      $display("FAIL random_pulses: got ok=%0d err=%0d ovr=%0d, required %0d %0d 0",
               ok_cnt, err_cnt, ovr_cnt, ok_exp, err_exp);
    end
    mism = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (got_q.size() != exp_q.size() || mism != 0) begin
      errors++;
      $display("FAIL random_data: got %0d beats with %0d mismatching, required %0d beats exact",
               got_q.size(), mism, exp_q.size());
    end
    checks++;
    if (stab_viol != 0 || multi_cnt != 0 || last_viol != 0) begin
      errors++;
      $display("FAIL random_protocol: got stab=%0d multi=%0d last=%0d, required 0 0 0",
               stab_viol, multi_cnt, last_viol);
    end
    $display("test_random done: %0d frames ok, %0d rejected, %0d beats", ok_exp, err_exp, exp_q.size());
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_bad_chk();
    test_bad_len();
    test_stall();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
